posit_decode_sequencer: RTL and testbench
=========================================

# posit_decode_sequencer

Operand sequencer that shares one posit_decoder between the two operands of a binary posit operation. It accepts an operand pair on a valid/ready handshake and runs A then B through the decoder, using the decoder's start / done / recieved protocol. It latches both decoded field bundles and presents them together on a valid/ready output to the downstream posit arithmetic stage. A watchdog flags a decoder that never completes.

## Interface
- TIMEOUT, 63: maximum WAIT cycles per operand before abort; legal range 1..255.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept a pair.
- in_a, in_b  in  32 each  posit operands.
- out_valid  out  1  decoded pair available.
- out_ready  in  1  downstream consumes the pair.
- a_sign, b_sign  out  1 each  decoded sign.
- a_k, b_k  out  6 each, signed  regime value.
- a_exp, b_exp  out  3 each  exponent field.
- a_mant, b_mant  out  32 each  mantissa with hidden bit.
- a_zero, a_nar, b_zero, b_nar  out  1 each  special-value flags.
- err  out  1  watchdog abort occurred during this pair.
- dec_posit  out  32  operand driven to the decoder.
- dec_start  out  1  decoder start.
- dec_recieved  out  1  decoder result acknowledge.
- dec_done, dec_sign, dec_zero, dec_nar  in  1 each  decoder outputs.
- dec_k  in  6, signed  decoder output.
- dec_exp  in  3  decoder output.
- dec_mant  in  32  decoder output.

## Operation
- States: IDLE, START_A, WAIT_A, ACK_A, SETTLE_A, START_B, WAIT_B, ACK_B, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_a and in_b, then go to START_A.
- START_x:
  - dec_posit=operand, dec_start=1 for exactly this cycle.
  - Clear the watchdog counter, then go to WAIT_x.
- WAIT_x:
  - dec_start=0; the counter increments each cycle.
  - On dec_done=1, capture all dec_* fields into the x registers, then go to ACK_x.
  - If the counter reaches TIMEOUT without dec_done:
    - capture x fields as sign=0, k=0, exp=0, mant=0, zero=0, nar=1;
    - set err;
    - go to ACK_x.
- ACK_x: dec_recieved=1 for exactly this cycle. ACK_A goes to SETTLE_A; ACK_B goes to OUT.
- SETTLE_A:
  - One cycle with dec_start=0, then go to START_B.
  - Mandatory: the decoder keeps done high until it sees start low in its idle state. Without this gap, WAIT_B would capture A's stale done.
- OUT:
  - out_valid=1; all a_*, b_* and err are held stable.
  - dec_start=0, which also settles the decoder.
  - On out_ready, go to IDLE and clear err.
- dec_posit holds the last driven operand outside START cycles.
- in_valid is ignored outside IDLE. dec_done is ignored outside WAIT states.
- dec_start, dec_recieved, in_ready and out_valid are registered-state decodes, with no combinational path from any input.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, err=0, dec_start=0, dec_recieved=0, dec_posit=0.
  - All a_*, b_* are 0; the watchdog counter is 0.
  - Reset mid-operation abandons the pair; the decoder shares rst.
- Decoder completion: dec_done is visible 6+r cycles after the START cycle, where r is the regime run length (r=1 gives 7).
- Latency: pair accepted in cycle 0; START_A in cycle 1; START_B in cycle 10+rA; out_valid in cycle 18+rA+rB.
- Throughput: one pair per 19+rA+rB cycles with out_ready held high. The next accept occurs in the IDLE cycle following OUT.
- out_valid stays high until out_ready; there is no timeout on output backpressure.
- The watchdog never fires when TIMEOUT ≥ 40; the decoder worst case is below 40 cycles.

## Test plan
- Reset: hold rst=0 mid-WAIT_A -> all outputs return immediately to the reset values above. After release, in_ready=1 and dec_start=0.
- Normal pair in_a=0x40000000, in_b=0x20000000, out_ready=1:
  - out_valid rises in cycle 20;
  - a: sign=0, k=0, exp=0, mant=0x80000000;
  - b: sign=0, k=-1, exp=0, mant=0x80000000;
  - err=0; exactly two dec_start pulses and two dec_recieved pulses.
- Specials in_a=0x00000000, in_b=0x80000000 -> a_zero=1, a_nar=0, b_nar=1, b_zero=0, err=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and new operands -> outputs stable, in_ready=0, no dec_start. Raise out_ready -> IDLE next cycle, then the new pair is accepted.
- Back-to-back pairs (0x40000000, 0x20000000) then (0x20000000, 0x40000000):
  - second-pair fields are correct, proving no stale-done capture;
  - dec_start is never high in the cycle immediately after dec_recieved.
- Watchdog: TIMEOUT=15 with a stub decoder holding dec_done=0:
  - ACK_A pulses dec_recieved in cycle 18;
  - out_valid eventually asserts with err=1, a_nar=1, b_nar=1.

Source files
------------

// File: rtl/posit_decode_sequencer.sv
// Shares one posit decoder between the A and B operands of a binary posit operation,
// presenting both decoded field bundles together on a valid/ready output with a decoder watchdog.
module posit_decode_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_in_a,
    input  logic [31:0]       i_in_b,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_a_sign,
    output logic signed [5:0] o_a_k,
    output logic [2:0]        o_a_exp,
    output logic [31:0]       o_a_mant,
    output logic              o_a_zero,
    output logic              o_a_nar,
    output logic              o_b_sign,
    output logic signed [5:0] o_b_k,
    output logic [2:0]        o_b_exp,
    output logic [31:0]       o_b_mant,
    output logic              o_b_zero,
    output logic              o_b_nar,
    output logic              o_err,
    output logic [31:0]       o_dec_posit,
    output logic              o_dec_start,
    output logic              o_dec_recieved,
    input  logic              i_dec_done,
    input  logic              i_dec_sign,
    input  logic              i_dec_zero,
    input  logic              i_dec_nar,
    input  logic signed [5:0] i_dec_k,
    input  logic [2:0]        i_dec_exp,
    input  logic [31:0]       i_dec_mant
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START_A  = 4'd1,
        S_WAIT_A   = 4'd2,
        S_ACK_A    = 4'd3,
        S_SETTLE_A = 4'd4,
        S_START_B  = 4'd5,
        S_WAIT_B   = 4'd6,
        S_ACK_B    = 4'd7,
        S_OUT      = 4'd8
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  exp;
        logic [31:0] mant;
        logic        zero;
        logic        nar;
    } fields_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
    // An aborted operand is reported as NaR so downstream arithmetic propagates the failure.
    localparam fields_t LP_ABORT = '{sign: 1'b0, k: 6'd0, exp: 3'd0, mant: 32'd0, zero: 1'b0, nar: 1'b1};

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wd_cnt;
    logic [31:0] r_op_b;
    logic [31:0] r_dec_posit;
    fields_t     r_a;
    fields_t     r_b;
    logic        r_err;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_dec_start;
    logic        r_dec_recieved;
    logic        w_in_ready_nx;
    logic        w_out_valid_nx;
    logic        w_dec_start_nx;
    logic        w_dec_recieved_nx;
    logic        w_timeout;
    fields_t     w_dec_fields;
    fields_t     w_capture;

    assign w_timeout    = (r_wd_cnt == LP_TIMEOUT);
    assign w_dec_fields = '{sign: i_dec_sign, k: i_dec_k, exp: i_dec_exp, mant: i_dec_mant,
                            zero: i_dec_zero, nar: i_dec_nar};
    assign w_capture    = i_dec_done ? w_dec_fields : LP_ABORT;

    // State register and registered handshake/strobe outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_dec_start    <= 1'b0;
            r_dec_recieved <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_in_ready     <= w_in_ready_nx;
            r_out_valid    <= w_out_valid_nx;
            r_dec_start    <= w_dec_start_nx;
            r_dec_recieved <= w_dec_recieved_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = i_in_valid ? S_START_A : S_IDLE;
            S_START_A:  w_next = S_WAIT_A;
            S_WAIT_A:   w_next = (i_dec_done || w_timeout) ? S_ACK_A : S_WAIT_A;
            S_ACK_A:    w_next = S_SETTLE_A;
            S_SETTLE_A: w_next = S_START_B;
            S_START_B:  w_next = S_WAIT_B;
            S_WAIT_B:   w_next = (i_dec_done || w_timeout) ? S_ACK_B : S_WAIT_B;
            S_ACK_B:    w_next = S_OUT;
            S_OUT:      w_next = i_out_ready ? S_IDLE : S_OUT;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered above so strobes align with their state.
    always_comb begin
        w_in_ready_nx     = 1'b0;
        w_out_valid_nx    = 1'b0;
        w_dec_start_nx    = 1'b0;
        w_dec_recieved_nx = 1'b0;
        case (w_next)
            S_IDLE:               w_in_ready_nx     = 1'b1;
            S_START_A, S_START_B: w_dec_start_nx    = 1'b1;
            S_ACK_A, S_ACK_B:     w_dec_recieved_nx = 1'b1;
            S_OUT:                w_out_valid_nx    = 1'b1;
            default:              w_in_ready_nx     = 1'b0;
        endcase
    end

    // Operand latch, decoder operand, watchdog counter, field capture and error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_b      <= 32'd0;
            r_dec_posit <= 32'd0;
            r_wd_cnt    <= 8'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_op_b      <= i_in_b;
                        r_dec_posit <= i_in_a;
                    end
                end
                S_START_A, S_START_B: r_wd_cnt <= 8'd0;
                S_WAIT_A: begin
                    if (i_dec_done || w_timeout) begin
                        r_a   <= w_capture;
                        r_err <= r_err | ~i_dec_done;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                S_SETTLE_A: r_dec_posit <= r_op_b;
                S_WAIT_B: begin
                    if (i_dec_done || w_timeout) begin
                        r_b   <= w_capture;
                        r_err <= r_err | ~i_dec_done;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: r_err <= r_err;
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_dec_start    = r_dec_start;
    assign o_dec_recieved = r_dec_recieved;
    assign o_dec_posit    = r_dec_posit;
    assign o_err          = r_err;
    assign o_a_sign       = r_a.sign;
    assign o_a_k          = r_a.k;
    assign o_a_exp        = r_a.exp;
    assign o_a_mant       = r_a.mant;
    assign o_a_zero       = r_a.zero;
    assign o_a_nar        = r_a.nar;
    assign o_b_sign       = r_b.sign;
    assign o_b_k          = r_b.k;
    assign o_b_exp        = r_b.exp;
    assign o_b_mant       = r_b.mant;
    assign o_b_zero       = r_b.zero;
    assign o_b_nar        = r_b.nar;

endmodule

// File: tb/tb_posit_decode_sequencer.sv
// Bench for posit_decode_sequencer: behavioural posit<32,2> decoder, table of operand pairs,
// scoreboard queue, plus backpressure, reset and watchdog sequences.
module tb_posit_decode_sequencer;

    typedef struct packed {
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  exp;
        logic [31:0] mant;
        logic        zero;
        logic        nar;
    } fld_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        fld_t        ea;
        fld_t        eb;
        int          lat;
        int          acc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_a = 32'd0, in_b = 32'd0;
    wire         o_in_ready, o_out_valid, o_a_sign, o_a_zero, o_a_nar, o_b_sign, o_b_zero, o_b_nar;
    wire         o_err, o_dec_start, o_dec_recieved;
    wire signed [5:0] o_a_k, o_b_k;
    wire [2:0]   o_a_exp, o_b_exp;
    wire [31:0]  o_a_mant, o_b_mant, o_dec_posit;

    logic        m_busy, m_done, m_ack;
    int          m_cnt, m_tgt;
    fld_t        m_f, m_pend;

    posit_decode_sequencer #(.TIMEOUT(63)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
        .o_a_sign(o_a_sign), .o_a_k(o_a_k), .o_a_exp(o_a_exp), .o_a_mant(o_a_mant),
        .o_a_zero(o_a_zero), .o_a_nar(o_a_nar), .o_b_sign(o_b_sign), .o_b_k(o_b_k),
        .o_b_exp(o_b_exp), .o_b_mant(o_b_mant), .o_b_zero(o_b_zero), .o_b_nar(o_b_nar),
        .o_err(o_err), .o_dec_posit(o_dec_posit), .o_dec_start(o_dec_start),
        .o_dec_recieved(o_dec_recieved), .i_dec_done(m_done), .i_dec_sign(m_f.sign),
        .i_dec_zero(m_f.zero), .i_dec_nar(m_f.nar), .i_dec_k(m_f.k), .i_dec_exp(m_f.exp),
        .i_dec_mant(m_f.mant)
    );

    // Second instance with a short watchdog and a decoder that never finishes.
    logic        w2_valid = 1'b0;
    logic        stub0 = 1'b0;
    logic [31:0] stub32 = 32'd0;
    logic [5:0]  stub6 = 6'd0;
    logic [2:0]  stub3 = 3'd0;
    wire         w2_in_ready, w2_out_valid, w2_a_sign, w2_a_zero, w2_a_nar, w2_b_sign, w2_b_zero, w2_b_nar;
    wire         w2_err, w2_start, w2_rcv;
    wire signed [5:0] w2_a_k, w2_b_k;
    wire [2:0]   w2_a_exp, w2_b_exp;
    wire [31:0]  w2_a_mant, w2_b_mant, w2_posit;

    posit_decode_sequencer #(.TIMEOUT(15)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(w2_valid), .o_in_ready(w2_in_ready),
        .i_in_a(32'h40000000), .i_in_b(32'h20000000), .o_out_valid(w2_out_valid), .i_out_ready(1'b1),
        .o_a_sign(w2_a_sign), .o_a_k(w2_a_k), .o_a_exp(w2_a_exp), .o_a_mant(w2_a_mant),
        .o_a_zero(w2_a_zero), .o_a_nar(w2_a_nar), .o_b_sign(w2_b_sign), .o_b_k(w2_b_k),
        .o_b_exp(w2_b_exp), .o_b_mant(w2_b_mant), .o_b_zero(w2_b_zero), .o_b_nar(w2_b_nar),
        .o_err(w2_err), .o_dec_posit(w2_posit), .o_dec_start(w2_start),
        .o_dec_recieved(w2_rcv), .i_dec_done(stub0), .i_dec_sign(stub0),
        .i_dec_zero(stub0), .i_dec_nar(stub0), .i_dec_k(stub6), .i_dec_exp(stub3),
        .i_dec_mant(stub32)
    );

    // Regime run length of a posit (31 for zero and NaR).
    function automatic int run_len(input logic [31:0] p);
        logic [31:0] v;
        int r;
        logic stop;
        v = p[31] ? -p : p;
        r = 0;
        stop = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (!stop && v[i] == v[30]) r++;
            else stop = 1'b1;
        end
        return r;
    endfunction

    function automatic fld_t posit_dec(input logic [31:0] p);
        fld_t d;
        logic [31:0] v;
        int r;
        d = '0;
        if (p == 32'h0) d.zero = 1'b1;
        else if (p == 32'h80000000) d.nar = 1'b1;
        else begin
            d.sign = p[31];
            v = p[31] ? -p : p;
            r = run_len(p);
            d.k = v[30] ? 6'(r - 1) : 6'(-r);
            v = v << (r + 2);
            d.exp = {1'b0, v[31:30]};
            d.mant = {1'b1, v[29:0], 1'b0};
        end
        return d;
    endfunction

    // Decoder model: done 6+r cycles after start, held until acknowledged and start seen low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ack <= 1'b0; m_cnt <= 0; m_tgt <= 0;
            m_f <= '0; m_pend <= '0;
        end else if (m_busy) begin
            if (m_cnt == m_tgt) begin
                m_done <= 1'b1; m_busy <= 1'b0; m_f <= m_pend;
            end else m_cnt <= m_cnt + 1;
        end else if (m_done) begin
            if (o_dec_recieved) m_ack <= 1'b1;
            if (m_ack && !o_dec_start) begin
                m_done <= 1'b0; m_ack <= 1'b0;
            end
        end else if (o_dec_start) begin
            m_busy <= 1'b1; m_cnt <= 0;
            m_pend <= posit_dec(o_dec_posit);
            m_tgt <= 4 + run_len(o_dec_posit);
        end
    end

    int   n_vec = 0, n_miss = 0, cyc = 0;
    int   n_start = 0, n_rcv = 0, n_gap = 0;
    logic prev_ov = 1'b0, prev_rcv = 1'b0;
    vec_t sb[$];
    vec_t cur;
    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_fields(input vec_t e);
        chk("a_sign", 32'(o_a_sign), 32'(e.ea.sign));
        chk("a_k", {26'd0, o_a_k}, {26'd0, e.ea.k});
        chk("a_exp", 32'(o_a_exp), 32'(e.ea.exp));
        chk("a_mant", o_a_mant, e.ea.mant);
        chk("a_zero", 32'(o_a_zero), 32'(e.ea.zero));
        chk("a_nar", 32'(o_a_nar), 32'(e.ea.nar));
        chk("b_sign", 32'(o_b_sign), 32'(e.eb.sign));
        chk("b_k", {26'd0, o_b_k}, {26'd0, e.eb.k});
        chk("b_exp", 32'(o_b_exp), 32'(e.eb.exp));
        chk("b_mant", o_b_mant, e.eb.mant);
        chk("b_zero", 32'(o_b_zero), 32'(e.eb.zero));
        chk("b_nar", 32'(o_b_nar), 32'(e.eb.nar));
        chk("err", 32'(o_err), 32'd0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_dec_start) begin
                if (sb.size() > 0) chk("dec_posit", o_dec_posit, (n_start == 0) ? sb[0].a : sb[0].b);
                n_start++;
            end
            if (o_dec_recieved) n_rcv++;
            if (prev_rcv && o_dec_start) n_gap++;
            prev_rcv = o_dec_recieved;
            if (o_out_valid && !prev_ov && sb.size() > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
            if (o_out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected output", 32'd1, 32'd0);
                else begin
                    check_fields(sb.pop_front());
                    chk("start pulses", n_start, 2);
                    chk("recieved pulses", n_rcv, 2);
                end
                n_start = 0; n_rcv = 0;
            end
            prev_ov = o_out_valid;
            if (in_valid && o_in_ready) begin
                cur.acc = cyc;
                sb.push_back(cur);
            end
        end
    end

    task automatic apply(input vec_t v);
        logic ok;
        @(posedge clk); #1;
        in_a = v.a; in_b = v.b; in_valid = 1'b1; cur = v;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_in_ready) begin ok = 1'b1; break; end
        end
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int rcv_c, ov_c;
        logic seen;
        tbl[0] = '{32'h40000000, 32'h20000000, '{1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0},
                   '{1'b0, 6'h3F, 3'd0, 32'h80000000, 1'b0, 1'b0}, 20, 0};
        tbl[1] = '{32'h00000000, 32'h80000000, '{1'b0, 6'd0, 3'd0, 32'h0, 1'b1, 1'b0},
                   '{1'b0, 6'd0, 3'd0, 32'h0, 1'b0, 1'b1}, 80, 0};
        tbl[2] = '{32'h20000000, 32'h40000000, '{1'b0, 6'h3F, 3'd0, 32'h80000000, 1'b0, 1'b0},
                   '{1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0}, 20, 0};
        tbl[3] = '{32'h4C000000, 32'h0A000000, '{1'b0, 6'd0, 3'd1, 32'hC0000000, 1'b0, 1'b0},
                   '{1'b0, 6'h3D, 3'd1, 32'h80000000, 1'b0, 1'b0}, 22, 0};
        tbl[4] = '{32'h60000000, 32'hC0000000, '{1'b0, 6'd1, 3'd0, 32'h80000000, 1'b0, 1'b0},
                   '{1'b1, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0}, 21, 0};
        tbl[5] = '{32'hB4000000, 32'h7FFFFFFF, '{1'b1, 6'd0, 3'd1, 32'hC0000000, 1'b0, 1'b0},
                   '{1'b0, 6'd30, 3'd0, 32'h80000000, 1'b0, 1'b0}, 50, 0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 32'(o_in_ready), 32'd1);
        chk("reset out_valid", 32'(o_out_valid), 32'd0);
        chk("reset dec_start", 32'(o_dec_start), 32'd0);

        // Back-to-back table pairs with out_ready held high.
        for (int i = 0; i < 6; i++) apply(tbl[i]);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

        // Backpressure: output held while a new pair waits at the input.
        out_ready = 1'b0;
        apply(tbl[3]);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_out_valid) begin seen = 1'b1; break; end
        end
        chk("bp out_valid", 32'(seen), 32'd1);
        @(posedge clk); #1;
        in_a = tbl[0].a; in_b = tbl[0].b; cur = tbl[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(o_in_ready), 32'd0);
            chk("bp dec_start", 32'(o_dec_start), 32'd0);
            chk("bp out_valid held", 32'(o_out_valid), 32'd1);
            if (sb.size() > 0) check_fields(sb[0]);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp idle in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

        // Reset in the middle of WAIT_A.
        apply(tbl[3]);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst in_ready", 32'(o_in_ready), 32'd1);
        chk("rst out_valid", 32'(o_out_valid), 32'd0);
        chk("rst err", 32'(o_err), 32'd0);
        chk("rst dec_start", 32'(o_dec_start), 32'd0);
        chk("rst dec_recieved", 32'(o_dec_recieved), 32'd0);
        chk("rst dec_posit", o_dec_posit, 32'd0);
        chk("rst a_mant", o_a_mant, 32'd0);
        chk("rst b_mant", o_b_mant, 32'd0);
        chk("rst a_k", {26'd0, o_a_k}, 32'd0);
        sb.delete();
        n_start = 0; n_rcv = 0; prev_ov = 1'b0; prev_rcv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 32'(o_in_ready), 32'd1);
        chk("post-rst dec_start", 32'(o_dec_start), 32'd0);
        apply(tbl[4]);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        chk("start right after ack", n_gap, 0);

        // Watchdog with a decoder that never raises done.
        @(posedge clk); #1 w2_valid = 1'b1;
        @(negedge clk);
        chk("wd accept", 32'(w2_in_ready), 32'd1);
        @(posedge clk); #1 w2_valid = 1'b0;
        rcv_c = -1; ov_c = -1;
        for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            if (w2_rcv && rcv_c < 0) rcv_c = c;
            if (w2_out_valid) begin ov_c = c; break; end
        end
        chk("wd ack_a cycle", rcv_c, 18);
        chk("wd out cycle", ov_c, 38);
        chk("wd err", 32'(w2_err), 32'd1);
        chk("wd a_nar", 32'(w2_a_nar), 32'd1);
        chk("wd b_nar", 32'(w2_b_nar), 32'd1);
        chk("wd a_mant", w2_a_mant, 32'd0);
        @(negedge clk);
        chk("wd err cleared", 32'(w2_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
